core_sequencer: RTL and testbench
=================================

CORE_SEQUENCER -- requirements
Module: core_sequencer

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 8'h00, giving the PC loaded at reset and at every start.
REQ-002 The block SHALL have parameter INSTR_W, default 20, giving the instruction width; only the value 20 is supported.
REQ-003 The block SHALL have input clk (1 bit): the single clock, with all state updating on its rising edge.
REQ-004 The block SHALL have input rst_n (1 bit): the reset, which is asynchronous and active-low.
REQ-005 The block SHALL have input start (1 bit): a one-cycle pulse that leaves IDLE or HALT and begins fetching at RESET_PC.
REQ-006 The block SHALL have output imem_req (1 bit) and output imem_addr (8 bits): the fetch request and the PC being fetched.
REQ-007 The block SHALL have input imem_ack (1 bit) and input imem_data (INSTR_W bits): the fetch completion and the instruction word, which is valid only while imem_ack=1.
REQ-008 The block SHALL have outputs alu_en (1), alu_opcode (4), imm_value (8), write_addr (4), ra_addr (4), rb_addr (4), write_en (1) and imm_flag (1): the datapath controls.
REQ-009 The block SHALL have inputs alu_zero (1) and alu_carry (1): the combinational flags from the datapath.
REQ-010 The block SHALL have outputs halted (1), err (1) and retired (16 bits): status outputs.

Function
REQ-011 The instruction fields SHALL be: [19:16] class, [15:12] alu_op, [11:8] rd, [7:4] ra, [3:0] rb, with imm = [7:0].
REQ-012 The FSM SHALL have the states IDLE, FETCH, EXEC and HALT.
REQ-013 The FSM transitions SHALL be: IDLE -> FETCH on start; FETCH -> EXEC on imem_ack; EXEC -> FETCH, except on HALT or trap, where EXEC -> HALT; HALT -> FETCH on start.
REQ-014 In FETCH, imem_req SHALL be 1 and imem_addr SHALL equal the PC, both held stable until the ack cycle; imem_data SHALL be captured into the IR on the ack cycle.
REQ-015 If imem_ack arrives on the first FETCH cycle, the instruction SHALL take 2 cycles (FETCH+EXEC); otherwise 2+N cycles for an ack delayed N cycles.
REQ-016 Datapath controls SHALL be driven only in EXEC, and write_en SHALL be a one-cycle pulse there; outside EXEC every control SHALL be 0.
REQ-017 Class 0 (NOP) SHALL have no write and PC+1.
REQ-018 Class 1 (ALU RR) SHALL drive alu_en=1, alu_opcode=alu_op, ra_addr=ra, rb_addr=rb, write_addr=rd, write_en=1 and imm_flag=0.
REQ-019 Class 2 (ALU RI) SHALL be as class 1 but with ra_addr=rd, imm_flag=1 and imm_value=imm.
REQ-020 Class 3 (LDI) SHALL drive alu_en=0, imm_value=imm, write_addr=rd and write_en=1.
REQ-021 Class 4 (JMP) SHALL set PC=imm.
REQ-022 Class 5 (BZ) SHALL set PC=imm if Z=1, else PC+1.
REQ-023 Class 6 (BC) SHALL set PC=imm if C=1, else PC+1.
REQ-024 Class 7 (HALT) SHALL set halted=1 and hold the PC.
REQ-025 Z and C SHALL be internal flag registers updated from alu_zero/alu_carry at the end of EXEC for classes 1 and 2 only; they SHALL be cleared by reset and by start.
REQ-026 A branch in the instruction immediately after an ALU op SHALL see that op's flags.
REQ-027 The PC SHALL increment modulo 256, so 8'hFF+1 = 8'h00.
REQ-028 retired SHALL increment once per completed EXEC, including HALT and trapped instructions, and SHALL saturate at 16'hFFFF.
REQ-029 A start pulse in FETCH or EXEC SHALL be ignored.
REQ-030 rd=0 writes SHALL still be issued; the datapath masks register 0.

Reset
REQ-031 rst_n=0 SHALL immediately force state IDLE, PC=RESET_PC, IR=0, Z=C=0, retired=0, halted=0, err=0, imem_req=0 and all datapath controls to 0, including mid-fetch, where imem_req drops without waiting for ack.
REQ-032 An imem_ack arriving after reset release while in IDLE SHALL be ignored.

Configuration
REQ-033 With macro CORE_SEQ_ILLEGAL_TRAP_EN defined, classes 8-15 SHALL be illegal: no write is issued, err=1, the FSM enters HALT, and err stays set until reset or start.
REQ-034 Without CORE_SEQ_ILLEGAL_TRAP_EN, classes 8-15 SHALL execute as NOP, and err SHALL be tied to 0.

Structure
REQ-035 Class encodings, state encoding and field bit positions SHALL live in the shared package core_pkg, with no literals in the RTL.
REQ-036 Decode SHALL be a combinational sub-module core_decode (IR in, controls plus next-PC select out); the FSM, PC, flags and counter SHALL stay in core_sequencer.

Verification
REQ-037 The bench SHALL cover: reset, start, then LDI r1,8'h05 with ack at the first FETCH cycle -> write_en pulses 1 cycle with write_addr=1, imm_value=8'h05, alu_en=0; retired=1 after 2 cycles.
REQ-038 The bench SHALL cover: ALU RI r1,r1+8'hFB (alu_op=ADD) with alu_carry=1 and alu_zero=1, followed by BC 8'h40 -> next imem_addr=8'h40; with alu_carry=0 instead -> next imem_addr=PC+1.
REQ-039 The bench SHALL cover: ack delayed 3 cycles -> imem_req and imem_addr stable for 4 cycles, with no datapath control asserted before EXEC.
REQ-040 The bench SHALL cover: JMP 8'hFF, then NOP at 8'hFF -> next fetch address is 8'h00.
REQ-041 The bench SHALL cover: rst_n low while imem_req=1 -> imem_req=0 asynchronously; after release, state is IDLE and a late ack is ignored.
REQ-042 The bench SHALL cover: class 4'hA with the macro defined -> err=1, halted=1, no write_en pulse; with the macro undefined -> NOP and PC+1.

Source files
------------

// File: rtl/core_pkg.sv
// Shared encodings for the core sequencer: instruction classes, FSM states,
// next-PC selects and instruction field positions.
package core_pkg;

    localparam int unsigned INSTR_WIDTH = 20;
    localparam int unsigned PC_W        = 8;
    localparam int unsigned REG_W       = 4;
    localparam int unsigned OP_W        = 4;
    localparam int unsigned IMM_W       = 8;
    localparam int unsigned RET_W       = 16;
    localparam int unsigned CLASS_W     = 4;
    localparam int unsigned PC_SEL_W    = 3;

    localparam int unsigned CLASS_HI  = 19;
    localparam int unsigned CLASS_LO  = 16;
    localparam int unsigned ALU_OP_HI = 15;
    localparam int unsigned ALU_OP_LO = 12;
    localparam int unsigned RD_HI     = 11;
    localparam int unsigned RD_LO     = 8;
    localparam int unsigned RA_HI     = 7;
    localparam int unsigned RA_LO     = 4;
    localparam int unsigned RB_HI     = 3;
    localparam int unsigned RB_LO     = 0;
    localparam int unsigned IMM_HI    = 7;
    localparam int unsigned IMM_LO    = 0;

    localparam logic [PC_W-1:0]  PC_STEP  = PC_W'(1);
    localparam logic [RET_W-1:0] RET_STEP = RET_W'(1);
    localparam logic [RET_W-1:0] RET_MAX  = '1;

    typedef enum logic [CLASS_W-1:0] {
        CLS_NOP    = 4'h0,
        CLS_ALU_RR = 4'h1,
        CLS_ALU_RI = 4'h2,
        CLS_LDI    = 4'h3,
        CLS_JMP    = 4'h4,
        CLS_BZ     = 4'h5,
        CLS_BC     = 4'h6,
        CLS_HALT   = 4'h7
    } instr_class_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_HALT  = 2'd3
    } state_e;

    typedef enum logic [PC_SEL_W-1:0] {
        PC_INC  = 3'd0,
        PC_IMM  = 3'd1,
        PC_BZ   = 3'd2,
        PC_BC   = 3'd3,
        PC_HOLD = 3'd4
    } pc_sel_e;

    function automatic logic [CLASS_W-1:0] ir_class(input logic [INSTR_WIDTH-1:0] ir);
        return ir[CLASS_HI:CLASS_LO];
    endfunction

    function automatic logic [OP_W-1:0] ir_alu_op(input logic [INSTR_WIDTH-1:0] ir);
        return ir[ALU_OP_HI:ALU_OP_LO];
    endfunction

    function automatic logic [REG_W-1:0] ir_rd(input logic [INSTR_WIDTH-1:0] ir);
        return ir[RD_HI:RD_LO];
    endfunction

    function automatic logic [REG_W-1:0] ir_ra(input logic [INSTR_WIDTH-1:0] ir);
        return ir[RA_HI:RA_LO];
    endfunction

    function automatic logic [REG_W-1:0] ir_rb(input logic [INSTR_WIDTH-1:0] ir);
        return ir[RB_HI:RB_LO];
    endfunction

    function automatic logic [IMM_W-1:0] ir_imm(input logic [INSTR_WIDTH-1:0] ir);
        return ir[IMM_HI:IMM_LO];
    endfunction

endpackage

// File: rtl/core_decode.sv
// Combinational instruction decode: IR in, datapath controls and next-PC select out.
// Classes 8-15 trap only when CORE_SEQ_ILLEGAL_TRAP_EN is defined, otherwise they act as NOP.
module core_decode
    import core_pkg::*;
(
    input  logic [INSTR_WIDTH-1:0] ir,
    output logic                   alu_en,
    output logic [OP_W-1:0]        alu_opcode,
    output logic [IMM_W-1:0]       imm_value,
    output logic [REG_W-1:0]       write_addr,
    output logic [REG_W-1:0]       ra_addr,
    output logic [REG_W-1:0]       rb_addr,
    output logic                   write_en,
    output logic                   imm_flag,
    output logic [PC_SEL_W-1:0]    pc_sel,
    output logic                   flag_upd,
    output logic                   is_halt,
    output logic                   is_trap
);

    always_comb begin
        alu_en     = '0;
        alu_opcode = '0;
        imm_value  = '0;
        write_addr = '0;
        ra_addr    = '0;
        rb_addr    = '0;
        write_en   = '0;
        imm_flag   = '0;
        pc_sel     = PC_INC;
        flag_upd   = '0;
        is_halt    = '0;
        is_trap    = '0;

        case (instr_class_e'(ir_class(ir)))
            CLS_NOP: ;
            CLS_ALU_RR: begin
                alu_en     = '1;
                alu_opcode = ir_alu_op(ir);
                ra_addr    = ir_ra(ir);
                rb_addr    = ir_rb(ir);
                write_addr = ir_rd(ir);
                write_en   = '1;
                flag_upd   = '1;
            end
            // Register-immediate reuses rd as the A operand; rb field is passed through.
            CLS_ALU_RI: begin
                alu_en     = '1;
                alu_opcode = ir_alu_op(ir);
                ra_addr    = ir_rd(ir);
                rb_addr    = ir_rb(ir);
                write_addr = ir_rd(ir);
                write_en   = '1;
                imm_flag   = '1;
                imm_value  = ir_imm(ir);
                flag_upd   = '1;
            end
            CLS_LDI: begin
                imm_value  = ir_imm(ir);
                write_addr = ir_rd(ir);
                write_en   = '1;
            end
            CLS_JMP:  pc_sel = PC_IMM;
            CLS_BZ:   pc_sel = PC_BZ;
            CLS_BC:   pc_sel = PC_BC;
            CLS_HALT: begin
                pc_sel  = PC_HOLD;
                is_halt = '1;
            end
            default: begin
`ifdef CORE_SEQ_ILLEGAL_TRAP_EN
                pc_sel  = PC_HOLD;
                is_trap = '1;
`endif
            end
        endcase
    end

endmodule

// File: rtl/core_sequencer.sv
// Fetch/execute sequencer: IDLE -> FETCH -> EXEC -> FETCH/HALT, owning PC, IR, Z/C flags and retire count.
// Optional macro CORE_SEQ_ILLEGAL_TRAP_EN turns classes 8-15 into traps that set err and halt.
module core_sequencer
    import core_pkg::*;
#(
    parameter logic [7:0]  RESET_PC = 8'h00,
    parameter int unsigned INSTR_W  = INSTR_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic               imem_req,
    output logic [7:0]         imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_data,
    output logic               alu_en,
    output logic [3:0]         alu_opcode,
    output logic [7:0]         imm_value,
    output logic [3:0]         write_addr,
    output logic [3:0]         ra_addr,
    output logic [3:0]         rb_addr,
    output logic               write_en,
    output logic               imm_flag,
    input  logic               alu_zero,
    input  logic               alu_carry,
    output logic               halted,
    output logic               err,
    output logic [15:0]        retired
);

    state_e                state, state_nx;
    logic [PC_W-1:0]       pc, pc_next;
    logic [INSTR_W-1:0]    ir;
    logic                  flag_z, flag_c;
    logic [RET_W-1:0]      retired_q;
    logic                  halted_q;
    logic                  restart;

    logic                  dec_alu_en;
    logic [OP_W-1:0]       dec_alu_opcode;
    logic [IMM_W-1:0]      dec_imm_value;
    logic [REG_W-1:0]      dec_write_addr;
    logic [REG_W-1:0]      dec_ra_addr;
    logic [REG_W-1:0]      dec_rb_addr;
    logic                  dec_write_en;
    logic                  dec_imm_flag;
    logic [PC_SEL_W-1:0]   dec_pc_sel;
    logic                  dec_flag_upd;
    logic                  dec_halt;
    logic                  dec_trap;

    core_decode u_decode (
        .ir         (ir),
        .alu_en     (dec_alu_en),
        .alu_opcode (dec_alu_opcode),
        .imm_value  (dec_imm_value),
        .write_addr (dec_write_addr),
        .ra_addr    (dec_ra_addr),
        .rb_addr    (dec_rb_addr),
        .write_en   (dec_write_en),
        .imm_flag   (dec_imm_flag),
        .pc_sel     (dec_pc_sel),
        .flag_upd   (dec_flag_upd),
        .is_halt    (dec_halt),
        .is_trap    (dec_trap)
    );

    assign restart   = start && (state == ST_IDLE || state == ST_HALT);
    assign imem_addr = pc;
    assign halted    = halted_q;
    assign retired   = retired_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        imem_req   = '0;
        alu_en     = '0;
        alu_opcode = '0;
        imm_value  = '0;
        write_addr = '0;
        ra_addr    = '0;
        rb_addr    = '0;
        write_en   = '0;
        imm_flag   = '0;

        case (state)
            ST_IDLE: begin
                if (start) state_nx = ST_FETCH;
            end
            ST_FETCH: begin
                imem_req = '1;
                if (imem_ack) state_nx = ST_EXEC;
            end
            ST_EXEC: begin
                alu_en     = dec_alu_en;
                alu_opcode = dec_alu_opcode;
                imm_value  = dec_imm_value;
                write_addr = dec_write_addr;
                ra_addr    = dec_ra_addr;
                rb_addr    = dec_rb_addr;
                write_en   = dec_write_en;
                imm_flag   = dec_imm_flag;
                state_nx   = (dec_halt || dec_trap) ? ST_HALT : ST_FETCH;
            end
            ST_HALT: begin
                if (start) state_nx = ST_FETCH;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Branches resolve against the registered flags, which the preceding ALU op just wrote.
    always_comb begin
        pc_next = pc + PC_STEP;
        case (pc_sel_e'(dec_pc_sel))
            PC_INC:  pc_next = pc + PC_STEP;
            PC_IMM:  pc_next = ir_imm(ir);
            PC_BZ:   pc_next = flag_z ? ir_imm(ir) : pc + PC_STEP;
            PC_BC:   pc_next = flag_c ? ir_imm(ir) : pc + PC_STEP;
            PC_HOLD: pc_next = pc;
            default: pc_next = pc + PC_STEP;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc        <= RESET_PC;
            ir        <= '0;
            flag_z    <= '0;
            flag_c    <= '0;
            retired_q <= '0;
            halted_q  <= '0;
        end else begin
            if (restart) begin
                pc       <= RESET_PC;
                flag_z   <= '0;
                flag_c   <= '0;
                halted_q <= '0;
            end
            if (state == ST_FETCH && imem_ack) begin
                ir <= imem_data;
            end
            if (state == ST_EXEC) begin
                pc <= pc_next;
                if (dec_flag_upd) begin
                    flag_z <= alu_zero;
                    flag_c <= alu_carry;
                end
                if (retired_q != RET_MAX) begin
                    retired_q <= retired_q + RET_STEP;
                end
                if (dec_halt || dec_trap) begin
                    halted_q <= '1;
                end
            end
        end
    end

`ifdef CORE_SEQ_ILLEGAL_TRAP_EN
    logic err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= '0;
        end else if (restart) begin
            err_q <= '0;
        end else if (state == ST_EXEC && dec_trap) begin
            err_q <= '1;
        end
    end

    assign err = err_q;
`else
    assign err = '0;
`endif

endmodule

// File: tb/tb_core_sequencer.sv
// Scoreboard bench for core_sequencer: stimulus queues expected fetches/writes, a monitor checks them.
module tb_core_sequencer;

    typedef struct packed {
        logic [3:0] wa;
        logic [7:0] imm;
        logic       alu_en;
        logic [3:0] op;
        logic [3:0] ra;
        logic [3:0] rb;
        logic       imm_flag;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_ack;
    logic [19:0] imem_data;
    logic        alu_en;
    logic [3:0]  alu_opcode;
    logic [7:0]  imm_value;
    logic [3:0]  write_addr;
    logic [3:0]  ra_addr;
    logic [3:0]  rb_addr;
    logic        write_en;
    logic        imm_flag;
    logic        alu_zero;
    logic        alu_carry;
    logic        halted;
    logic        err;
    logic [15:0] retired;

    int vectors = 0;
    int miscompares = 0;
    logic [7:0] exp_fetch[$];
    wr_t        exp_wr[$];

    localparam wr_t NO_WR = '0;

    core_sequencer #(
        .RESET_PC (8'h10),
        .INSTR_W  (20)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_data  (imem_data),
        .alu_en     (alu_en),
        .alu_opcode (alu_opcode),
        .imm_value  (imm_value),
        .write_addr (write_addr),
        .ra_addr    (ra_addr),
        .rb_addr    (rb_addr),
        .write_en   (write_en),
        .imm_flag   (imm_flag),
        .alu_zero   (alu_zero),
        .alu_carry  (alu_carry),
        .halted     (halted),
        .err        (err),
        .retired    (retired)
    );

    always #5 clk = ~clk;

    function automatic wr_t mk_wr(input logic [3:0] wa, input logic [7:0] imm, input logic ae,
                                  input logic [3:0] op, input logic [3:0] ra, input logic [3:0] rb,
                                  input logic imf);
        wr_t w;
        w.wa = wa; w.imm = imm; w.alu_en = ae; w.op = op; w.ra = ra; w.rb = rb; w.imm_flag = imf;
        return w;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Serve one fetch at 'addr' after 'delay' wait cycles, then let EXEC complete.
    task automatic do_instr(input logic [7:0] addr, input logic [19:0] instr, input int unsigned delay,
                            input logic z, input logic c, input logic has_wr, input wr_t wr,
                            input logic pulse_start);
        int unsigned waited = 0;
        while (imem_req !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (imem_req !== 1'b1) begin
            vectors++;
            miscompares++;
            $display("FAIL fetch_timeout: got imem_req=%b expected 1 for addr %0h", imem_req, addr);
            return;
        end
        for (int unsigned d = 0; d < delay; d++) begin
            start = pulse_start && (d == 0);
            check("fetch_hold_req", 32'(imem_req), 32'h1);
            check("fetch_hold_addr", 32'(imem_addr), 32'(addr));
            check("no_ctrl_in_fetch", 32'({write_en, alu_en, imm_flag, alu_opcode, imm_value}), 32'h0);
            @(negedge clk);
        end
        start = 1'b0;
        exp_fetch.push_back(addr);
        if (has_wr) exp_wr.push_back(wr);
        imem_ack  = 1'b1;
        imem_data = instr;
        alu_zero  = z;
        alu_carry = c;
        @(negedge clk);
        imem_ack  = 1'b0;
        imem_data = '0;
        @(negedge clk);
        alu_zero  = 1'b0;
        alu_carry = 1'b0;
    endtask

    task automatic pulse_start;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin : monitor
        logic [7:0] ea;
        wr_t        ew;
        wr_t        aw;
        forever begin
            @(negedge clk);
            #1;
            if (imem_req === 1'b1 && imem_ack === 1'b1) begin
                if (exp_fetch.size() == 0) begin
                    check("unexpected_fetch_ack", 32'(imem_addr), 32'hFFFF_FFFF);
                end else begin
                    ea = exp_fetch.pop_front();
                    check("fetch_addr", 32'(imem_addr), 32'(ea));
                end
            end
            if (write_en !== 1'b0) begin
                aw = {write_addr, imm_value, alu_en, alu_opcode, ra_addr, rb_addr, imm_flag};
                if (exp_wr.size() == 0) begin
                    check("unexpected_write", 32'(aw), 32'hFFFF_FFFF);
                end else begin
                    ew = exp_wr.pop_front();
                    check("write_ctrl", 32'(aw), 32'(ew));
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        rst_n     = 1'b0;
        start     = 1'b0;
        imem_ack  = 1'b0;
        imem_data = '0;
        alu_zero  = 1'b0;
        alu_carry = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_imem_req", 32'(imem_req), 32'h0);
        check("rst_retired", 32'(retired), 32'h0);
        check("rst_status", 32'({halted, err}), 32'h0);
        check("rst_ctrl", 32'({write_en, alu_en, imm_flag, write_addr, imm_value}), 32'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_no_req", 32'(imem_req), 32'h0);

        pulse_start();
        // LDI r1, 0x05 with ack on the first FETCH cycle
        do_instr(8'h10, 20'h30105, 0, 0, 0, 1, mk_wr(4'h1, 8'h05, 0, 4'h0, 4'h0, 4'h0, 0), 0);
        check("retired_after_ldi", 32'(retired), 32'h1);
        // ALU RI r1 = r1 + 0xFB (ADD=1), carry/zero set, then BC 0x40 taken
        do_instr(8'h11, 20'h211FB, 0, 1, 1, 1, mk_wr(4'h1, 8'hFB, 1, 4'h1, 4'h1, 4'hB, 1), 0);
        do_instr(8'h12, 20'h60040, 0, 0, 0, 0, NO_WR, 0);
        // same ALU op with carry clear, then BC not taken
        do_instr(8'h40, 20'h211FB, 0, 0, 0, 1, mk_wr(4'h1, 8'hFB, 1, 4'h1, 4'h1, 4'hB, 1), 0);
        do_instr(8'h41, 20'h60040, 0, 0, 0, 0, NO_WR, 0);
        // ALU RR r2 = r3 op5 r4 with ack delayed 3 cycles, zero set, then BZ 0x80 taken
        do_instr(8'h42, 20'h15234, 3, 1, 0, 1, mk_wr(4'h2, 8'h00, 1, 4'h5, 4'h3, 4'h4, 0), 0);
        do_instr(8'h43, 20'h50080, 0, 0, 0, 0, NO_WR, 0);
        // JMP 0xFF, NOP at 0xFF wraps to 0x00
        do_instr(8'h80, 20'h400FF, 0, 0, 0, 0, NO_WR, 0);
        do_instr(8'hFF, 20'h00000, 0, 0, 0, 0, NO_WR, 0);
        // LDI r0, 0xAA (write still issued), stray start during FETCH ignored
        do_instr(8'h00, 20'h300AA, 1, 0, 0, 1, mk_wr(4'h0, 8'hAA, 0, 4'h0, 4'h0, 4'h0, 0), 1);
        // illegal class 0xA
        do_instr(8'h01, 20'hA1234, 0, 0, 0, 0, NO_WR, 0);
`ifdef CORE_SEQ_ILLEGAL_TRAP_EN
        check("trap_err", 32'(err), 32'h1);
        check("trap_halted", 32'(halted), 32'h1);
        check("trap_no_req", 32'(imem_req), 32'h0);
        check("trap_retired", 32'(retired), 32'd11);
        pulse_start();
        check("restart_clears", 32'({halted, err}), 32'h0);
        do_instr(8'h10, 20'h70000, 0, 0, 0, 0, NO_WR, 0);
`else
        check("illegal_as_nop_err", 32'(err), 32'h0);
        check("illegal_as_nop_halted", 32'(halted), 32'h0);
        do_instr(8'h02, 20'h70000, 0, 0, 0, 0, NO_WR, 0);
`endif
        check("halt_halted", 32'(halted), 32'h1);
        check("halt_retired", 32'(retired), 32'd12);
        check("halt_no_req", 32'(imem_req), 32'h0);
        repeat (2) @(negedge clk);
        check("halt_stays", 32'({halted, imem_req}), 32'h2);

        // start clears Z, so BZ falls through
        pulse_start();
        check("start_clears_halted", 32'(halted), 32'h0);
        do_instr(8'h10, 20'h50020, 0, 1, 1, 0, NO_WR, 0);

        // reset mid-fetch drops imem_req without a clock edge
        begin
            int unsigned w = 0;
            while (imem_req !== 1'b1 && w < 20) begin
                @(negedge clk);
                w++;
            end
        end
        check("prereset_req", 32'(imem_req), 32'h1);
        check("prereset_addr", 32'(imem_addr), 32'h11);
        rst_n = 1'b0;
        #1;
        check("async_rst_req", 32'(imem_req), 32'h0);
        check("async_rst_retired", 32'(retired), 32'h0);
        check("async_rst_ctrl", 32'({write_en, alu_en, halted, err}), 32'h0);
        @(negedge clk);
        rst_n     = 1'b1;
        imem_ack  = 1'b1;
        imem_data = 20'h30155;
        @(negedge clk);
        check("late_ack_idle_req", 32'(imem_req), 32'h0);
        imem_ack  = 1'b0;
        imem_data = '0;
        @(negedge clk);
        check("late_ack_retired", 32'(retired), 32'h0);
        check("late_ack_req", 32'(imem_req), 32'h0);

        pulse_start();
        do_instr(8'h10, 20'h3073C, 0, 0, 0, 1, mk_wr(4'h7, 8'h3C, 0, 4'h0, 4'h0, 4'h0, 0), 0);
        check("retired_after_reset", 32'(retired), 32'h1);

        repeat (3) @(negedge clk);
        check("fetch_queue_empty", 32'(exp_fetch.size()), 32'h0);
        check("write_queue_empty", 32'(exp_wr.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
